wide_add_sequencer: RTL and testbench
=====================================

# wide_add_sequencer

Multi-precision add/subtract controller that time-shares one 16-bit carry-lookahead adder to compute WORDS×16-bit sums. It latches the full operands on a start handshake and steps the shared adder one 16-bit word per cycle, least significant word first, chaining the carry through a register. It then presents the wide result with carry-out and signed-overflow flags. It sits between the experiment's operand registers and the display/result registers, replacing a full-width combinational adder.

## Interface
- WORDS, 4: number of 16-bit words per operand (≥2); total width W = 16·WORDS.
- Clk  in  1  system clock, all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- Sub  in  1  0 = A+B, 1 = A−B; latched with Start.
- A  in  W  operand A; latched with Start.
- B  in  W  operand B; latched with Start.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse in DONE.
- Sum  out  W  result; holds its value until the next accepted Start completes word 0.
- Cout  out  1  carry out of the top word; for Sub, 1 = no borrow.
- Ovf  out  1  signed overflow of the W-bit operation.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on Start.
  - RUN → DONE after word WORDS−1 is processed.
  - DONE → RUN on Start, else DONE → IDLE.
- On an accepted Start:
  - latch A into opA and (Sub ? ~B : B) into opB;
  - carry register ← Sub;
  - word index ← 0;
  - Cout and Ovf ← 0.
- Each RUN cycle:
  - the adder sees opA[16k+15:16k], opB[16k+15:16k] and the carry register;
  - Sum[16k+15:16k] ← adder sum;
  - carry register ← adder carry-out;
  - k ← k+1.
- On the last word:
  - Cout ← adder carry-out;
  - Ovf ← carry into bit 15 XOR carry-out, where carry into bit 15 = a15 ^ b15 ^ s15 of that word.
- Start in RUN is ignored, with no queueing. A, B and Sub changing during RUN have no effect.
- All arithmetic is modulo 2^W. No saturation.

## Timing
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE, k = 0, carry = 0;
  - Sum = 0, Cout = 0, Ovf = 0, Busy = 0, Done = 0;
  - any partial result is discarded.
- Start sampled at edge t0. Word k is written at edge t0+k+1. Done is high for exactly the cycle after edge t0+WORDS.
- Latency from Start to Done is WORDS cycles.
- Back-to-back throughput is one operation per WORDS+1 cycles when Start is held in the DONE cycle.
- Busy and Done are never high together. Done is never high for two consecutive cycles unless a new operation completes.
- Sum, Cout and Ovf are valid and stable while Done is high and afterwards, until word 0 of the next operation is written.

## Structure
- Shared package `wide_add_pkg`:
  - state enum `wa_state_t` {IDLE, RUN, DONE};
  - constant WORD_W = 16.
- One sub-module, `add16`: a combinational 16-bit CLA with A, B, Cin, S and Cout. It is instantiated exactly once and must not be replicated per word.
- The word index counter is $clog2(WORDS) bits wide. Word selection uses an indexed part-select on the latched operands.

## Test plan
All scenarios use WORDS = 4.
- Add 0x0000_0000_0000_FFFF + 0x1, Sub = 0 → Sum = 0x0000_0000_0001_0000, Cout = 0, Ovf = 0; Done exactly 4 cycles after the Start edge.
- Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 → Sum = 0, Cout = 1, Ovf = 0; the carry ripples across all four words.
- Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 → Sum = 0x8000_0000_0000_0000, Cout = 0, Ovf = 1.
- Sub 5 − 7 → Sum = 0xFFFF_FFFF_FFFF_FFFE, Cout = 0 (borrow), Ovf = 0. Then Sub 7 − 5, started in the DONE cycle → Sum = 2, Cout = 1, with no IDLE cycle in between.
- Pulse Start again two cycles into RUN, with different A/B → it is ignored; the original result completes with a single Done pulse.
- Drive Reset_n low during word 2 of an operation → all outputs are 0 and the state is IDLE immediately. A fresh Start after release produces the correct sum, with no carry left over from the aborted operation.

Source files
------------

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package wide_add_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wa_state_t;

endpackage

// File: rtl/add16.sv
// Combinational 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module add16 (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  assign g = A & B;
  assign p = A ^ B;

  for (genvar i = 0; i < 4; i++) begin : g_grp
    assign gg[i] = g[4*i+3]
                 | (p[4*i+3] & g[4*i+2])
                 | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                 | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    assign gp[i] = &p[4*i +: 4];

    assign c[4*i]   = gc[i];
    assign c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
    assign c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
    assign c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                    | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
  end

  // Second-level lookahead across the four groups.
  assign gc[0] = Cin;
  assign gc[1] = gg[0] | (gp[0] & Cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & Cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & Cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & Cin);

  assign S    = p ^ c;
  assign Cout = gc[4];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract: one shared 16-bit CLA stepped LSW-first, carry chained
// through a register, producing a WORDS*16-bit result with carry-out and signed overflow.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      Start,
  input  logic                      Sub,
  input  logic [WORDS*WORD_W-1:0]   A,
  input  logic [WORDS*WORD_W-1:0]   B,
  output logic                      Busy,
  output logic                      Done,
  output logic [WORDS*WORD_W-1:0]   Sum,
  output logic                      Cout,
  output logic                      Ovf
);

  localparam int W   = WORDS * WORD_W;
  localparam int K_W = $clog2(WORDS);

  wa_state_t         state;
  wa_state_t         state_next;
  logic [K_W-1:0]    k;
  logic              carry;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              accept;
  logic              last;
  logic [WORD_W-1:0] word_a;
  logic [WORD_W-1:0] word_b;
  logic [WORD_W-1:0] word_s;
  logic              word_cout;

  assign accept = Start && (state != RUN);
  assign last   = (k == K_W'(WORDS - 1));
  assign word_a = op_a[k*WORD_W +: WORD_W];
  assign word_b = op_b[k*WORD_W +: WORD_W];

  add16 u_add16 (
    .A    (word_a),
    .B    (word_b),
    .Cin  (carry),
    .S    (word_s),
    .Cout (word_cout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (Start) state_next = RUN;
      RUN:     if (last)  state_next = DONE;
      DONE:    state_next = Start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN);
    Done = (state == DONE);
  end

  // Operands need no reset: they are always reloaded before the adder consumes them.
  always_ff @(posedge Clk) begin
    if (accept) begin
      op_a <= A;
      op_b <= Sub ? ~B : B;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      k     <= '0;
      carry <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else if (accept) begin
      k     <= '0;
      carry <= Sub;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else if (state == RUN) begin
      Sum[k*WORD_W +: WORD_W] <= word_s;
      carry <= word_cout;
      k     <= last ? '0 : k + 1'b1;
      if (last) begin
        Cout <= word_cout;
        // Carry into the sign bit recovered from the sum; differs from carry-out on overflow.
        Ovf  <= (word_a[WORD_W-1] ^ word_b[WORD_W-1] ^ word_s[WORD_W-1]) ^ word_cout;
      end
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer: stimulus pushes expected results, a monitor
// pops and checks them whenever Done is presented.
module tb_wide_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic         clk;
  logic         Reset_n;
  logic         Start;
  logic         Sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   tests    = 0;
  int   failures = 0;
  int   cyc      = 0;

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .Clk     (clk),
    .Reset_n (Reset_n),
    .Start   (Start),
    .Sub     (Sub),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Sum     (Sum),
    .Cout    (Cout),
    .Ovf     (Ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Reset_n === 1'b1 && Done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        failures++;
        $display("FAIL unexpected_done: got Done=1 at cycle %0d, expected no result pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum",     Sum,          e.sum);
        check("cout",    W'(Cout),     W'(e.cout));
        check("ovf",     W'(Ovf),      W'(e.ovf));
        check("latency", W'(cyc),      W'(e.due));
        check("busy_with_done", W'(Busy), '0);
      end
    end
  end

  // Called at a negedge; drives Start for exactly one edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input logic expect_result, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
    exp_t e;
    A     = a;
    B     = b;
    Sub   = sub;
    Start = 1'b1;
    if (expect_result) begin
      e.sum  = exp_sum;
      e.cout = exp_cout;
      e.ovf  = exp_ovf;
      e.due  = cyc + WORDS + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      tests++;
      failures++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] ones;
    bit           seen;
    ones    = '1;
    Reset_n = 1'b0;
    Start   = 1'b0;
    Sub     = 1'b0;
    A       = '0;
    B       = '0;
    repeat (2) @(negedge clk);
    check("rst_sum",  Sum,       '0);
    check("rst_busy", W'(Busy),  '0);
    check("rst_done", W'(Done),  '0);
    check("rst_cout", W'(Cout),  '0);
    check("rst_ovf",  W'(Ovf),   '0);
    Reset_n = 1'b1;
    @(negedge clk);

    start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    wait_drain();
    start_op(ones, 64'h1, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    wait_drain();
    start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    wait_drain();
    start_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    wait_drain();

    // Back-to-back: second Start issued in the DONE cycle of the first.
    start_op(64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tests++;
    if (!seen) begin
      failures++;
      $display("FAIL b2b_done_timeout: got no Done, expected Done within 20 cycles");
    end
    start_op(64'd7, 64'd5, 1'b1, 1'b1, 64'd2, 1'b1, 1'b0);
    wait_drain();

    // Start pulsed mid-RUN must be ignored.
    start_op(64'd3, 64'd4, 1'b0, 1'b1, 64'd7, 1'b0, 1'b0);
    @(negedge clk);
    start_op(64'd100, 64'd200, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    wait_drain();
    repeat (6) @(negedge clk);

    // Reset asserted while word 2 is in the adder.
    start_op(64'h1111_2222_3333_4444, 64'h1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    Reset_n = 1'b0;
    #1;
    check("midrst_sum",  Sum,      '0);
    check("midrst_busy", W'(Busy), '0);
    check("midrst_done", W'(Done), '0);
    check("midrst_cout", W'(Cout), '0);
    check("midrst_ovf",  W'(Ovf),  '0);
    @(negedge clk);
    Reset_n = 1'b1;
    @(negedge clk);
    start_op(64'd1, 64'd2, 1'b0, 1'b1, 64'd3, 1'b0, 1'b0);
    wait_drain();
    repeat (6) @(negedge clk);

    check("queue_empty", W'(sb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
